frame_buffer_dp: RTL and testbench
==================================

# frame_buffer_dp

Parametrised dual-port frame buffer for the camera datapath: one write port fed by the capture side, one read port drained by the display/readout side, both on a single clock. It generalises the fixed 32K×16 buffer with configurable width and depth, a registered read with a valid strobe, address range checking, and a hardware clear sweep that fills the whole memory with a constant after reset or on request.

## Interface
- `DW`, 16, data word width in bits.
- `AW`, 15, address width in bits.
- `MEM_DEPTH`, 19200, number of words implemented; must satisfy `MEM_DEPTH <= 2**AW`.
- `CLEAR_VAL`, 0, word written to every location by the clear sweep.
- `INIT_CLEAR`, 1, 1 = run a clear sweep automatically after reset release; 0 = come out of reset ready.

Ports:
- `clk`, in, 1, sole clock; rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `addr_in`, in, AW, write address.
- `data_in`, in, DW, write data.
- `regwrite`, in, 1, write enable.
- `addr_out`, in, AW, read address.
- `regread`, in, 1, read enable.
- `clear_req`, in, 1, one-cycle pulse requesting a clear sweep.
- `data_out`, out, DW, registered read data.
- `data_valid`, out, 1, `data_out` was updated by a read this cycle.
- `addr_err`, out, 1, one-cycle pulse: a write or read addressed `>= MEM_DEPTH`.
- `busy`, out, 1, clear sweep in progress; ports ignored.

## Operation
- FSM states: `RUN`, `CLEAR`.
- In reset: state = `CLEAR` if `INIT_CLEAR=1`, else `RUN`; sweep pointer = 0.
- `CLEAR`: each cycle writes `CLEAR_VAL` at the pointer and increments it. The cycle the pointer holds `MEM_DEPTH-1`: write it, then go to `RUN`. `busy=1` throughout. `regwrite`, `regread` and `clear_req` are ignored. `data_valid=0`. `data_out` holds its value.
- `RUN`, `clear_req=1`: go to `CLEAR` with the pointer at 0. Any write or read in the same cycle is still performed.
- `RUN`, `regwrite=1` and `addr_in < MEM_DEPTH`: write `data_in` to `addr_in`.
- Write with `addr_in >= MEM_DEPTH`: dropped; `addr_err` pulses.
- `RUN`, `regread=1` and `addr_out < MEM_DEPTH`: `data_out` takes `mem[addr_out]`.
- Read with `addr_out >= MEM_DEPTH`: `data_out` takes 0; `addr_err` pulses.
- Reads in either of the two cases above assert `data_valid`.
- `regread=0`: `data_out` holds its previous value; `data_valid=0`.
- Read and write to the same valid address in the same cycle: behaviour is selected by the configuration macro.
- Memory contents are not touched by reset itself. With `INIT_CLEAR=0`, contents are undefined until written.

## Timing
- Reset values: `data_out=0`, `data_valid=0`, `addr_err=0`, `busy=INIT_CLEAR`.
- Read latency is 1 cycle. `regread` sampled at edge N gives `data_out`/`data_valid` valid after edge N, for one cycle.
- Write is visible to a read sampled at edge N+1 or later.
- Clear sweep:
  - `busy` rises the cycle after the `clear_req` edge.
  - The sweep lasts exactly `MEM_DEPTH` cycles.
  - `busy` falls after the edge that writes the last location; ports are accepted from the next edge.
- `addr_err` is registered and asserted for exactly one cycle per offending access. A write and a read both out of range in one cycle give a single pulse.
- Reset asserted mid-sweep: immediate return to reset values. After release, the sweep restarts at address 0 if `INIT_CLEAR=1`; otherwise the state is `RUN` with partially cleared memory.
- Sweep pointer width is AW and never exceeds `MEM_DEPTH-1`.

## Configuration
- `FRAME_BUFFER_WR_BYPASS_EN`:
  - Defined: a same-cycle read and write to the same valid address returns the new `data_in` on `data_out` (write-first).
  - Undefined: it returns the old stored word (read-first), which is the plain BRAM behaviour.

## Test plan
All scenarios use `DW=16`, `AW=4`, `MEM_DEPTH=12`, `CLEAR_VAL=16'hA5A5`, `INIT_CLEAR=1`.
- Release reset → `busy=1` for exactly 12 cycles. Reads of addresses 0..11 afterwards return `16'hA5A5`, each with `data_valid=1` one cycle after `regread`.
- Write 234 to address 0, then read address 0 on the next cycle → `data_out=234`, `data_valid=1` one cycle later. With `regread=0` afterwards, 234 is held and `data_valid=0`.
- Write to address 13 with data 7 → `addr_err` pulses once; a read of 13 → `data_out=0`, `data_valid=1`, `addr_err` pulse; address 1 still `16'hA5A5`.
- Store 5 at address 3, then read and write address 3 with data 9 in the same cycle → `data_out=5` without the macro, `data_out=9` with `FRAME_BUFFER_WR_BYPASS_EN`. A following read returns 9 in both cases.
- Pulse `clear_req` after writing 1..12 to addresses 0..11; assert `regwrite` at address 2 during the sweep → `busy` high 12 cycles, the write is ignored, all addresses read `16'hA5A5`.
- Assert `rst_n=0` at sweep cycle 5, release → outputs return to reset values and a full 12-cycle sweep runs from address 0.

Source files
------------

// File: rtl/frame_buffer_dp.sv
// frame_buffer_dp: single-clock dual-port frame buffer with registered read,
// address range checking and a hardware clear sweep.
//
// Optional feature: define FRAME_BUFFER_WR_BYPASS_EN to make a same-cycle read
// and write of the same valid address return the new write data (write-first).
// Without it the old stored word is returned (read-first, plain BRAM behaviour).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   addr_in, data_in    write address / data, regwrite = write enable
//   addr_out, regread   read address / read enable
//   clear_req           one-cycle pulse starting a clear sweep
//   data_out            registered read data
//   data_valid          data_out was updated by a read this cycle
//   addr_err            one-cycle pulse for an out-of-range write or read
//   busy                clear sweep in progress, port requests ignored
module frame_buffer_dp #(
    parameter int unsigned    DW         = 16,
    parameter int unsigned    AW         = 15,
    parameter int unsigned    MEM_DEPTH  = 19200,
    parameter logic [DW-1:0]  CLEAR_VAL  = '0,
    parameter bit             INIT_CLEAR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] data_in,
    input  logic          regwrite,
    input  logic [AW-1:0] addr_out,
    input  logic          regread,
    input  logic          clear_req,
    output logic [DW-1:0] data_out,
    output logic          data_valid,
    output logic          addr_err,
    output logic          busy
);

    localparam int unsigned   IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(MEM_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   ptr_q;
    logic [DW-1:0]   mem [MEM_DEPTH];

    logic            wr_in_range_c;
    logic            rd_in_range_c;
    logic            wr_hit_c;
    logic            bypass_c;
    logic            mem_we_c;
    logic [AW-1:0]   mem_waddr_c;
    logic [DW-1:0]   mem_wdata_c;

    // Range checks and the shared write port: the sweep owns it while clearing.
    always_comb begin
        wr_in_range_c = {1'b0, addr_in}  < DEPTH_LIM;
        rd_in_range_c = {1'b0, addr_out} < DEPTH_LIM;
        wr_hit_c      = (state_q == RUN) && regwrite && wr_in_range_c;
        mem_we_c      = 1'b0;
        mem_waddr_c   = addr_in;
        mem_wdata_c   = data_in;
        if (state_q == CLEAR) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = ptr_q;
            mem_wdata_c = CLEAR_VAL;
        end else if (wr_hit_c) begin
            mem_we_c    = 1'b1;
        end
    end

`ifdef FRAME_BUFFER_WR_BYPASS_EN
    assign bypass_c = wr_hit_c && (addr_in == addr_out);
`else
    assign bypass_c = 1'b0;
`endif

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[IDX_W'(mem_waddr_c)] <= mem_wdata_c;
        end
    end

    // Control FSM, sweep pointer and registered read side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT_CLEAR ? CLEAR : RUN;
            ptr_q      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            addr_err   <= 1'b0;
            busy       <= INIT_CLEAR;
        end else begin
            data_valid <= 1'b0;
            addr_err   <= 1'b0;
            case (state_q)
                RUN: begin
                    // A write and a read both out of range still give one pulse.
                    addr_err <= (regwrite && !wr_in_range_c) ||
                                (regread  && !rd_in_range_c);
                    if (regread) begin
                        data_valid <= 1'b1;
                        if (!rd_in_range_c) begin
                            data_out <= '0;
                        end else if (bypass_c) begin
                            data_out <= data_in;
                        end else begin
                            data_out <= mem[IDX_W'(addr_out)];
                        end
                    end
                    if (clear_req) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Pointer wraps to 0 so it never exceeds MEM_DEPTH-1.
                    if (ptr_q == LAST_ADDR) begin
                        state_q <= RUN;
                        ptr_q   <= '0;
                        busy    <= 1'b0;
                    end else begin
                        ptr_q   <= ptr_q + AW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_dp.sv
// Self-checking bench for frame_buffer_dp (DW=16, AW=4, MEM_DEPTH=12,
// CLEAR_VAL=16'hA5A5, INIT_CLEAR=1): directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_frame_buffer_dp;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 12;
    localparam logic [15:0] CV    = 16'hA5A5;
`ifdef FRAME_BUFFER_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite;
    logic [AW-1:0] addr_out;
    logic          regread;
    logic          clear_req;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          addr_err;
    logic          busy;

    frame_buffer_dp #(
        .DW         (DW),
        .AW         (AW),
        .MEM_DEPTH  (DEPTH),
        .CLEAR_VAL  (CV),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .regwrite   (regwrite),
        .addr_out   (addr_out),
        .regread    (regread),
        .clear_req  (clear_req),
        .data_out   (data_out),
        .data_valid (data_valid),
        .addr_err   (addr_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [15:0] mmem [DEPTH];
    int          sweep_left;
    logic [15:0] e_out;
    logic        e_valid;
    logic        e_err;
    logic        e_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sweep_left = int'(DEPTH);
        e_out      = 16'h0;
        e_valid    = 1'b0;
        e_err      = 1'b0;
        e_busy     = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data_out"},   32'(data_out),   32'(e_out));
        check({tag, ".data_valid"}, 32'(data_valid), 32'(e_valid));
        check({tag, ".addr_err"},   32'(addr_err),   32'(e_err));
        check({tag, ".busy"},       32'(busy),       32'(e_busy));
    endtask

    // One clock of traffic; model advanced after the edge, outputs compared.
    task automatic step(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                        input logic r, input logic [3:0] ra, input logic c);
        regwrite  = w;
        addr_in   = wa;
        data_in   = wd;
        regread   = r;
        addr_out  = ra;
        clear_req = c;
        @(posedge clk);
        #1;
        e_valid = 1'b0;
        e_err   = 1'b0;
        if (sweep_left > 0) begin
            mmem[4'(int'(DEPTH) - sweep_left)] = CV;
            sweep_left--;
        end else begin
            e_err = (w && 32'(wa) >= DEPTH) || (r && 32'(ra) >= DEPTH);
            if (r) begin
                e_valid = 1'b1;
                if (32'(ra) >= DEPTH)           e_out = 16'h0;
                else if (BYP && w && wa == ra)  e_out = wd;
                else                            e_out = mmem[ra];
            end
            if (w && 32'(wa) < DEPTH) mmem[wa] = wd;
            if (c) sweep_left = int'(DEPTH);
        end
        e_busy = (sweep_left > 0);
        check_outputs("step");
        regwrite  = 1'b0;
        regread   = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0);
    endtask
    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        step(1'b1, a, d, 1'b0, 4'd0, 1'b0);
    endtask
    task automatic rd(input logic [3:0] a);
        step(1'b0, 4'd0, 16'h0, 1'b1, a, 1'b0);
    endtask

    // Assert reset away from the clock edge, check reset values, release.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Idle (optionally writing addr 2) until busy drops; returns cycles busy.
    task automatic wait_sweep(input logic poke, output int n);
        n = 0;
        while (busy && n < 50) begin
            step(poke, 4'd2, 16'h0BAD, 1'b0, 4'd0, 1'b0);
            n++;
        end
    endtask

    task automatic read_all_clear(input string tag);
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd(4'(i));
            check(tag, 32'(data_out), 32'(CV));
            check({tag, ".valid"}, 32'(data_valid), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        regwrite  = 1'b0;
        regread   = 1'b0;
        clear_req = 1'b0;
        addr_in   = '0;
        addr_out  = '0;
        data_in   = '0;
        for (int i = 0; i < int'(DEPTH); i++) mmem[i] = 16'h0;
        #12;

        // Reset, then the automatic sweep
        do_reset();
        wait_sweep(1'b0, n);
        check("init_sweep_len", 32'(n), 32'd12);
        read_all_clear("init_clear_rd");

        // Write then read, then hold
        wr(4'd0, 16'd234);
        rd(4'd0);
        check("rd0", 32'(data_out), 32'd234);
        check("rd0.valid", 32'(data_valid), 32'd1);
        idle();
        check("hold", 32'(data_out), 32'd234);
        check("hold.valid", 32'(data_valid), 32'd0);

        // Out-of-range accesses
        wr(4'd13, 16'd7);
        check("wr13.err", 32'(addr_err), 32'd1);
        idle();
        check("err_pulse_end", 32'(addr_err), 32'd0);
        rd(4'd13);
        check("rd13", 32'(data_out), 32'd0);
        check("rd13.valid", 32'(data_valid), 32'd1);
        check("rd13.err", 32'(addr_err), 32'd1);
        step(1'b1, 4'd14, 16'd1, 1'b1, 4'd15, 1'b0);
        check("both_oor.err", 32'(addr_err), 32'd1);
        idle();
        check("both_oor.single", 32'(addr_err), 32'd0);
        rd(4'd1);
        check("rd1", 32'(data_out), 32'(CV));

        // Same-cycle read/write collision
        wr(4'd3, 16'd5);
        step(1'b1, 4'd3, 16'd9, 1'b1, 4'd3, 1'b0);
        check("collide", 32'(data_out), BYP ? 32'd9 : 32'd5);
        rd(4'd3);
        check("after_collide", 32'(data_out), 32'd9);

        // Requested sweep with a write attempted during it
        for (int i = 0; i < int'(DEPTH); i++) wr(4'(i), 16'(i + 1));
        rd(4'd11);
        check("pre_clr_rd11", 32'(data_out), 32'd12);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1);
        check("clr_busy_rise", 32'(busy), 32'd1);
        wait_sweep(1'b1, n);
        check("req_sweep_len", 32'(n), 32'd12);
        read_all_clear("req_clear_rd");

        // Reset in the middle of a sweep
        for (int i = 0; i < int'(DEPTH); i++) wr(4'(i), 16'(i + 100));
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 5; i++) idle();
        do_reset();
        check("midrst.data_out", 32'(data_out), 32'd0);
        wait_sweep(1'b0, n);
        check("midrst_sweep_len", 32'(n), 32'd12);
        read_all_clear("midrst_clear_rd");

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
